ram_8: RTL and testbench



---
 rtl/hack_pkg.sv | 14 +
 rtl/dmux_8_way.sv | 41 ++++
 rtl/mux_8_way_16.sv | 36 +++
 rtl/register_16.sv | 32 +++
 rtl/ram_8.sv | 59 +++++
 tb/tb_ram_8.sv | 140 ++++++++++++++
 6 files changed

// File: rtl/hack_pkg.sv
// hack_pkg: shared constants and types for the Hack memory hierarchy.
//   WORD_WIDTH      - data word width of the Hack platform
//   RAM8_DEPTH      - number of words in one ram_8 bank
//   RAM8_ADDR_WIDTH - address bits needed to select a word in ram_8
//   word_t          - one Hack data word
package hack_pkg;

  localparam int WORD_WIDTH      = 16;
  localparam int RAM8_DEPTH      = 8;
  localparam int RAM8_ADDR_WIDTH = 3;

  typedef logic [WORD_WIDTH-1:0] word_t;

endpackage : hack_pkg

// File: rtl/dmux_8_way.sv
// dmux_8_way: routes a single input bit to one of eight outputs.
//   in     - bit to route
//   sel    - output select, 0 -> a ... 7 -> h
//   a..h   - outputs; only the selected one follows in, the rest are 0
module dmux_8_way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h
);

  // Steer in to the selected output, all others forced low.
  always_comb begin
    a = 1'b0;
    b = 1'b0;
    c = 1'b0;
    d = 1'b0;
    e = 1'b0;
    f = 1'b0;
    g = 1'b0;
    h = 1'b0;
    case (sel)
      3'd0:    a = in;
      3'd1:    b = in;
      3'd2:    c = in;
      3'd3:    d = in;
      3'd4:    e = in;
      3'd5:    f = in;
      3'd6:    g = in;
      3'd7:    h = in;
      default: a = 1'b0;
    endcase
  end

endmodule : dmux_8_way

// File: rtl/mux_8_way_16.sv
// mux_8_way_16: combinational eight-input word multiplexer.
//   a..h   - candidate words
//   select - 0 -> a ... 7 -> h
//   out    - selected word
module mux_8_way_16 import hack_pkg::*; #(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [WIDTH-1:0]           c,
  input  logic [WIDTH-1:0]           d,
  input  logic [WIDTH-1:0]           e,
  input  logic [WIDTH-1:0]           f,
  input  logic [WIDTH-1:0]           g,
  input  logic [WIDTH-1:0]           h,
  input  logic [RAM8_ADDR_WIDTH-1:0] select,
  output logic [WIDTH-1:0]           out
);

  // Word selection by address.
  always_comb begin
    out = {WIDTH{1'b0}};
    case (select)
      3'd0:    out = a;
      3'd1:    out = b;
      3'd2:    out = c;
      3'd3:    out = d;
      3'd4:    out = e;
      3'd5:    out = f;
      3'd6:    out = g;
      3'd7:    out = h;
      default: out = {WIDTH{1'b0}};
    endcase
  end

endmodule : mux_8_way_16

// File: rtl/register_16.sv
// register_16: one word register with synchronous clear and load enable.
//   clk  - rising-edge clock
//   rst  - synchronous active-high clear, overrides load
//   in   - data to store
//   load - store in on the next rising edge
//   out  - stored word
module register_16 import hack_pkg::*; #(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] word_r;

  // Word storage: clear has priority, otherwise load or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_r <= {WIDTH{1'b0}};
    end else if (load) begin
      word_r <= in;
    end else begin
      word_r <= word_r;
    end
  end

  assign out = word_r;

endmodule : register_16

// File: rtl/ram_8.sv
// ram_8: eight-word register file, first tier of the Hack RAM hierarchy.
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset, clears all words, beats load
//   in      - write data
//   load    - write enable for the word at address
//   address - word select 0..7 for both write and read
//   out     - contents of word address, combinational (no bypass of in)
// Pure wiring: load decoder, eight registers and a read multiplexer.
module ram_8 import hack_pkg::*; #(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in,
  input  logic                       load,
  input  logic [RAM8_ADDR_WIDTH-1:0] address,
  output logic [WIDTH-1:0]           out
);

  logic [RAM8_DEPTH-1:0] load_s;
  logic [WIDTH-1:0]      word_s [RAM8_DEPTH];

  dmux_8_way u_load_dmux (
    .in  (load),
    .sel (address),
    .a   (load_s[0]),
    .b   (load_s[1]),
    .c   (load_s[2]),
    .d   (load_s[3]),
    .e   (load_s[4]),
    .f   (load_s[5]),
    .g   (load_s[6]),
    .h   (load_s[7])
  );

  for (genvar i = 0; i < RAM8_DEPTH; i++) begin : g_word
    register_16 #(.WIDTH(WIDTH)) u_reg (
      .clk  (clk),
      .rst  (rst),
      .in   (in),
      .load (load_s[i]),
      .out  (word_s[i])
    );
  end

  mux_8_way_16 #(.WIDTH(WIDTH)) u_read_mux (
    .a      (word_s[0]),
    .b      (word_s[1]),
    .c      (word_s[2]),
    .d      (word_s[3]),
    .e      (word_s[4]),
    .f      (word_s[5]),
    .g      (word_s[6]),
    .h      (word_s[7]),
    .select (address),
    .out    (out)
  );

endmodule : ram_8

// File: tb/tb_ram_8.sv
// tb_ram_8: self-checking bench for ram_8 against an array reference model.
module tb_ram_8;

  logic        clk;
  logic        rst;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;

  logic [15:0] mem [8];
  int          checks;
  int          errors;

  ram_8 #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check old value, update model, check new value.
  task automatic cycle(input logic r, input logic ld, input logic [2:0] a,
                       input logic [15:0] d, input bit pre_ok);
    @(negedge clk);
    rst = r; load = ld; address = a; in = d;
    #1;
    if (pre_ok) check_eq("pre_edge", out, mem[a]);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    end else if (ld) begin
      mem[a] = d;
    end
    #1;
    check_eq("post_edge", out, mem[a]);
  endtask

  // Read every address with writes disabled.
  task automatic sweep(input string tag);
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1;
      check_eq(tag, out, mem[i]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; load = 1'b0; address = 3'd0; in = 16'h0000;
    for (int i = 0; i < 8; i++) mem[i] = 16'hxxxx;

    // First reset, with a discarded write.
    cycle(1'b1, 1'b1, 3'd5, 16'h1234, 1'b0);
    sweep("reset_initial");

    // Reset clear after filling with ones.
    for (int n = 0; n < 8; n++) cycle(1'b0, 1'b1, 3'(n), 16'hFFFF, 1'b1);
    sweep("fill_ones");
    cycle(1'b1, 1'b1, 3'd5, 16'h1234, 1'b1);
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1;
      check_eq("reset_clear", out, 16'h0000);
    end

    // Write/read each word.
    for (int n = 0; n < 8; n++) cycle(1'b0, 1'b1, 3'(n), 16'h1000 + 16'(n), 1'b1);
    sweep("word_n");

    // Same-address read during write.
    cycle(1'b0, 1'b1, 3'd3, 16'hAAAA, 1'b1);
    @(negedge clk);
    address = 3'd3; in = 16'h5555; load = 1'b1;
    #1;
    check_eq("rdw_before", out, 16'hAAAA);
    @(posedge clk);
    mem[3] = 16'h5555;
    #1;
    check_eq("rdw_after", out, 16'h5555);

    // Isolation: preload 0..7 then write address 6.
    for (int n = 0; n < 8; n++) cycle(1'b0, 1'b1, 3'(n), 16'(n), 1'b1);
    cycle(1'b0, 1'b1, 3'd6, 16'hBEEF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load = 1'b0; address = 3'(i);
      #1;
      check_eq("isolation", out, (i == 6) ? 16'hBEEF : 16'(i));
    end

    // load=0 hold with toggling data.
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 3'(k % 8),
            (k % 3 == 0) ? 16'h0001 : ((k % 3 == 1) ? 16'h8000 : 16'h7FFF), 1'b1);
    end
    sweep("hold");

    // Back-to-back writes.
    cycle(1'b0, 1'b1, 3'd7, 16'h0011, 1'b1);
    cycle(1'b0, 1'b1, 3'd7, 16'h0022, 1'b1);
    cycle(1'b0, 1'b1, 3'd0, 16'h0033, 1'b1);
    @(negedge clk);
    load = 1'b0; address = 3'd7;
    #1;
    check_eq("b2b_r7", out, 16'h0022);
    address = 3'd0;
    #1;
    check_eq("b2b_r0", out, 16'h0033);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)),
            16'($urandom), 1'b1);
    end
    sweep("random_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ram_8
